// File: rtl/fifo_144bit_wr_packer.sv
// Packs pairs of 72-bit stream beats into 144-bit FIFO words; WR_PACK_STATS_EN adds word/pad counters.
// Latency: word on din/wr_en one cycle after its completing beat; one beat absorbed per cycle.
// Backpressure: while full holds a pending word, in_ready drops and din/pad_flag stay frozen.
module fifo_144bit_wr_packer #(
  parameter int HSIZE = 72,
  parameter int CNTW  = 32
) (
  input  logic               wr_clk,
  input  logic               wr_rst,
  input  logic [HSIZE-1:0]   in_data,
  input  logic               in_valid,
  input  logic               in_last,
  output logic               in_ready,
  output logic [2*HSIZE-1:0] din,
  output logic               wr_en,
  input  logic               full,
  output logic               pad_flag,
  output logic [CNTW-1:0]    word_cnt,
  output logic [CNTW-1:0]    pad_cnt
);

  localparam logic [0:0] ST_LO = 1'b0;
  localparam logic [0:0] ST_HI = 1'b1;

  typedef struct packed {
    logic [HSIZE-1:0] hi;
    logic [HSIZE-1:0] lo;
  } word_t;

  logic [0:0]       state;
  logic [HSIZE-1:0] lo_reg;
  word_t            out_word;
  logic             out_pend;
  logic             acc;
  logic             form;

  assign din      = out_word;
  assign wr_en    = out_pend && !full && !wr_rst;
  assign in_ready = !wr_rst && (!out_pend || !full);
  assign acc      = in_valid && in_ready;
  // A word completes on the second beat of a pair or on a lone last beat.
  assign form     = acc && ((state == ST_HI) || in_last);

  always_ff @(posedge wr_clk) begin
    if (wr_rst) begin
      state    <= ST_LO;
      lo_reg   <= '0;
      out_word <= '0;
      out_pend <= 1'b0;
      pad_flag <= 1'b0;
    end else begin
      if (acc) begin
        if (state == ST_LO) begin
          if (in_last) begin
            out_word <= '{hi: '0, lo: in_data};
            pad_flag <= 1'b1;
          end else begin
            lo_reg <= in_data;
            state  <= ST_HI;
          end
        end else begin
          out_word <= '{hi: in_data, lo: lo_reg};
          pad_flag <= 1'b0;
          state    <= ST_LO;
        end
      end
      // A word formed in the same cycle as a write keeps the slot occupied.
      if (form)
        out_pend <= 1'b1;
      else if (wr_en)
        out_pend <= 1'b0;
    end
  end

`ifdef WR_PACK_STATS_EN
  always_ff @(posedge wr_clk) begin
    if (wr_rst) begin
      word_cnt <= '0;
      pad_cnt  <= '0;
    end else if (wr_en) begin
      word_cnt <= word_cnt + CNTW'(1);
      if (pad_flag)
        pad_cnt <= pad_cnt + CNTW'(1);
    end
  end
`else
  assign word_cnt = '0;
  assign pad_cnt  = '0;
`endif

  a_no_write_when_full: assert property (@(posedge wr_clk) !(wr_en && full));

endmodule

// File: tb/tb_fifo_144bit_wr_packer.sv
// Bench for fifo_144bit_wr_packer: directed scenarios plus randomized traffic against a queue-based model.
module tb_fifo_144bit_wr_packer;

  localparam int HSIZE = 72;
  localparam int CNTW  = 4;

  typedef struct packed {
    logic [2*HSIZE-1:0] w;
    logic               pad;
  } ent_t;

  logic               clk = 1'b0;
  logic               rst;
  logic [HSIZE-1:0]   in_data;
  logic               in_valid;
  logic               in_last;
  logic               in_ready;
  logic [2*HSIZE-1:0] din;
  logic               wr_en;
  logic               full;
  logic               pad_flag;
  logic [CNTW-1:0]    word_cnt;
  logic [CNTW-1:0]    pad_cnt;

  fifo_144bit_wr_packer #(.HSIZE(HSIZE), .CNTW(CNTW)) dut (
    .wr_clk   (clk),
    .wr_rst   (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_last  (in_last),
    .in_ready (in_ready),
    .din      (din),
    .wr_en    (wr_en),
    .full     (full),
    .pad_flag (pad_flag),
    .word_cnt (word_cnt),
    .pad_cnt  (pad_cnt)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int wr_seen = 0;

  // Reference model: pending words in a queue, the half-built pair in have_lo/lo_val.
  ent_t            pq[$];
  bit              have_lo = 1'b0;
  logic [HSIZE-1:0] lo_val = '0;
  logic [CNTW-1:0] m_wc = '0;
  logic [CNTW-1:0] m_pc = '0;

  task automatic chk(string tag, logic [2*HSIZE-1:0] obs, logic [2*HSIZE-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(bit v, bit l, logic [HSIZE-1:0] d, bit f, bit r);
    in_valid = v;
    in_last  = l;
    in_data  = d;
    full     = f;
    rst      = r;
  endtask

  function automatic logic [CNTW-1:0] exp_cnt(logic [CNTW-1:0] c);
`ifdef WR_PACK_STATS_EN
    return c;
`else
    return '0;
`endif
  endfunction

  // Called at a negedge with inputs already applied; checks, advances the model, moves to the next negedge.
  task automatic tick();
    bit er;
    bit ew;
    #1;
    er = !rst && (pq.size() == 0 || !full);
    ew = (pq.size() != 0) && !full && !rst;
    chk("in_ready", {143'd0, in_ready}, {143'd0, er});
    chk("wr_en", {143'd0, wr_en}, {143'd0, ew});
    if (pq.size() != 0) begin
      chk("din", din, pq[0].w);
      chk("pad_flag", {143'd0, pad_flag}, {143'd0, pq[0].pad});
    end
    chk("word_cnt", {140'd0, word_cnt}, {140'd0, exp_cnt(m_wc)});
    chk("pad_cnt", {140'd0, pad_cnt}, {140'd0, exp_cnt(m_pc)});
    if (wr_en) wr_seen++;
    if (rst) begin
      pq.delete();
      have_lo = 1'b0;
      m_wc = '0;
      m_pc = '0;
    end else begin
      if (ew) begin
        m_wc = m_wc + 1'b1;
        if (pq[0].pad) m_pc = m_pc + 1'b1;
        void'(pq.pop_front());
      end
      if (in_valid && er) begin
        if (have_lo) begin
          pq.push_back('{w: {in_data, lo_val}, pad: 1'b0});
          have_lo = 1'b0;
        end else if (in_last) begin
          pq.push_back('{w: {{HSIZE{1'b0}}, in_data}, pad: 1'b1});
        end else begin
          lo_val  = in_data;
          have_lo = 1'b1;
        end
      end
    end
    @(negedge clk);
  endtask

  initial begin
    drive(0, 0, '0, 0, 1);
    @(negedge clk);
    #1;
    chk("rst_din", din, '0);
    chk("rst_pad_flag", {143'd0, pad_flag}, '0);
    chk("rst_in_ready", {143'd0, in_ready}, '0);
    chk("rst_wr_en", {143'd0, wr_en}, '0);
    tick();

    // Odd last beat, then held off by full for five cycles.
    drive(1, 1, 72'hAB, 0, 0);
    tick();
    drive(1, 0, 72'h33, 1, 0);
    #1;
    chk("odd_din", din, {72'h0, 72'hAB});
    chk("odd_pad_flag", {143'd0, pad_flag}, 144'd1);
    repeat (5) tick();
    drive(0, 0, '0, 0, 0);
    #1;
    chk("bp_resume_wr_en", {143'd0, wr_en}, 144'd1);
    tick();
    tick();
    #1;
    chk("odd_word_cnt", {140'd0, word_cnt}, {140'd0, exp_cnt(4'd1)});
    chk("odd_pad_cnt", {140'd0, pad_cnt}, {140'd0, exp_cnt(4'd1)});

    // Plain pair.
    drive(1, 0, 72'h1, 0, 0);
    tick();
    drive(1, 1, 72'h2, 0, 0);
    tick();
    drive(0, 0, '0, 0, 0);
    #1;
    chk("pack_wr_en", {143'd0, wr_en}, 144'd1);
    chk("pack_din", din, {72'h2, 72'h1});
    chk("pack_pad_flag", {143'd0, pad_flag}, '0);
    tick();

    // Reset discards a half-built pair.
    drive(1, 0, 72'h5, 0, 0);
    tick();
    drive(0, 0, '0, 0, 1);
    tick();
    drive(1, 0, 72'h6, 0, 0);
    tick();
    drive(1, 1, 72'h7, 0, 0);
    tick();
    drive(0, 0, '0, 0, 0);
    #1;
    chk("rst_pair_din", din, {72'h7, 72'h6});
    tick();

    // Sixteen back-to-back beats.
    wr_seen = 0;
    for (int i = 0; i < 16; i++) begin
      drive(1, i == 15, 72'(100 + i), 0, 0);
      tick();
    end
    drive(0, 0, '0, 0, 0);
    tick();
    chk("stream_words", 144'(wr_seen), 144'd8);

    // Seventeen words after reset: 4-bit counter wraps to 1.
    drive(0, 0, '0, 0, 1);
    tick();
    for (int i = 0; i < 34; i++) begin
      drive(1, 1'b0, 72'(1000 + i), 0, 0);
      tick();
    end
    drive(0, 0, '0, 0, 0);
    tick();
    #1;
    chk("wrap_word_cnt", {140'd0, word_cnt}, {140'd0, exp_cnt(4'd1)});

    // Randomized traffic.
    for (int i = 0; i < 800; i++) begin
      drive(($urandom % 4) != 0, ($urandom % 3) == 0,
            72'({$urandom, $urandom, $urandom}),
            ($urandom % 4) == 0, ($urandom % 97) == 0);
      tick();
    end
    drive(0, 0, '0, 0, 0);
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
